// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: request type codes, access sizes
// and FSM states.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        STORE_WORD      = 2'b00,
        STORE_HALF_WORD = 2'b01,
        STORE_BYTE      = 2'b10
    } store_type_e;

    typedef enum logic [2:0] {
        LOAD_WORD        = 3'b000,
        LOAD_HALF_WORD   = 3'b001,
        LOAD_HALF_WORD_U = 3'b010,
        LOAD_BYTE        = 3'b011,
        LOAD_BYTE_U      = 3'b100
    } load_type_e;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, write-data replication, load lane
// extraction/extension and alignment/encoding error detection.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic        is_write,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        err
);

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
        logic signed [7:0] sb;
        logic signed [31:0] sw;
        sb = b;
        sw = 32'(sb);
        return sgn ? sw : {24'b0, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        logic signed [31:0] sw;
        sh = h;
        sw = 32'(sh);
        return sgn ? sw : {16'b0, h};
    endfunction

    access_size_e size;
    logic         known;
    logic         sgn;
    logic         misaligned;
    logic [31:0]  shifted;

    always_comb begin
        size  = SIZE_WORD;
        known = 1'b0;
        sgn   = 1'b0;
        if (is_write) begin
            case (store_type)
                STORE_WORD:      begin size = SIZE_WORD; known = 1'b1; end
                STORE_HALF_WORD: begin size = SIZE_HALF; known = 1'b1; end
                STORE_BYTE:      begin size = SIZE_BYTE; known = 1'b1; end
                default:         begin size = SIZE_WORD; known = 1'b0; end
            endcase
        end else begin
            case (load_type)
                LOAD_WORD:        begin size = SIZE_WORD; known = 1'b1; end
                LOAD_HALF_WORD:   begin size = SIZE_HALF; known = 1'b1; sgn = 1'b1; end
                LOAD_HALF_WORD_U: begin size = SIZE_HALF; known = 1'b1; end
                LOAD_BYTE:        begin size = SIZE_BYTE; known = 1'b1; sgn = 1'b1; end
                LOAD_BYTE_U:      begin size = SIZE_BYTE; known = 1'b1; end
                default:          begin size = SIZE_WORD; known = 1'b0; end
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        // Little-endian: lane n sits at bits 8n+7:8n, so shift it down to bit 0.
        shifted    = rdata >> {addr_lo, 3'b000};
        case (size)
            SIZE_HALF: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = extend16(shifted[15:0], sgn);
            end
            SIZE_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = extend8(shifted[7:0], sgn);
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
        err = !known || misaligned;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store engine between the control FSM and the SoC
// data bus, with alignment checking and a bus wait timeout.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        store_type,
    input  logic [2:0]        load_type,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        load_type_q, load_type_d;

    logic              idle;
    logic [3:0]        align_be;
    logic [31:0]       align_wdata;
    logic [31:0]       align_rdata;
    logic              align_err;

    // One aligner serves both phases: live request fields while idle,
    // latched fields while the bus transfer is in flight.
    assign idle = (state_q == IDLE);

    mem_lane_align u_align (
        .is_write   (idle ? req_write : bus_we_q),
        .addr_lo    (idle ? req_addr[1:0] : addr_lo_q),
        .store_type (store_type),
        .load_type  (idle ? load_type : load_type_q),
        .wdata      (req_wdata),
        .rdata      (bus_rdata),
        .be         (align_be),
        .wdata_lane (align_wdata),
        .rdata_ext  (align_rdata),
        .err        (align_err)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        cnt_d       = cnt_q;
        addr_lo_d   = addr_lo_q;
        load_type_d = load_type_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    addr_lo_d   = req_addr[1:0];
                    load_type_d = load_type;
                    bus_we_d    = req_write;
                    if (align_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d     = BUS;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        bus_be_d    = align_be;
                        bus_wdata_d = align_wdata;
                    end
                end
            end
            BUS: begin
                // A completing handshake wins over an expiring timeout.
                if (bus_ready) begin
                    state_d     = RESP;
                    bus_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = bus_we_q ? 32'h0 : align_rdata;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = RESP;
                    bus_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                    cnt_d       = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0;
                req_ready_d = 1'b1;
                cnt_d       = '0;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                bus_valid_d = 1'b0;
                rsp_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            cnt_q       <= '0;
            addr_lo_q   <= 2'b00;
            load_type_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            cnt_q       <= cnt_d;
            addr_lo_q   <= addr_lo_d;
            load_type_q <= load_type_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
